// File: rtl/grb_serializer.sv
// WS2812B frame serializer: fetches NUM_LEDS GRB words from a synchronous pixel buffer and
// drives the strip data pin, then the reset code. Define GRB_DIM_EN for quarter-brightness loads.
module grb_serializer #(
  parameter int NUM_LEDS = 64,
  parameter int ADDR_W   = 6,
  parameter int T0H      = 40,
  parameter int T1H      = 80,
  parameter int TBIT     = 125,
  parameter int TRESET   = 30000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shipGRB,
  input  logic [23:0]       pixel_grb,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              dout,
  output logic              Done,
  output logic              allDone
);

  localparam int BIT_W = $clog2(TBIT);
  localparam int PIX_W = $clog2(NUM_LEDS + 1);
  localparam int RST_W = $clog2(TRESET + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(TBIT - 1);
  localparam logic [BIT_W-1:0]  T0H_CNT    = BIT_W'(T0H);
  localparam logic [BIT_W-1:0]  T1H_CNT    = BIT_W'(T1H);
  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(NUM_LEDS - 1);
  localparam logic [RST_W-1:0]  RST_LAST   = RST_W'(TRESET);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = (NUM_LEDS > 1) ? ADDR_W'(1) : ADDR_LAST;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, RESETCODE} state_t;

  state_t            state_reg;
  logic [23:0]       shift_reg;
  logic [BIT_W-1:0]  bit_cnt_reg;
  logic [4:0]        bit_idx_reg;
  logic [PIX_W-1:0]  pix_cnt_reg;
  logic [RST_W-1:0]  rst_cnt_reg;
  logic [23:0]       load_word;

`ifdef GRB_DIM_EN
  logic [5:0] unused_low_bits;

  // Each channel is divided by four as it enters the shift register.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dim
    assign load_word[gi*8 +: 8] = {2'b00, pixel_grb[gi*8+2 +: 6]};
  end
  assign unused_low_bits = {pixel_grb[17:16], pixel_grb[9:8], pixel_grb[1:0]};
`else
  assign load_word = pixel_grb;
`endif

  // dout and Done are registered from the counters, so they trail the internal state by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      pix_cnt_reg <= '0;
      rst_cnt_reg <= '0;
      pixel_addr  <= '0;
      dout        <= 1'b0;
      Done        <= 1'b0;
      allDone     <= 1'b0;
    end else begin
      dout    <= 1'b0;
      Done    <= 1'b0;
      allDone <= 1'b0;
      case (state_reg)
        IDLE: begin
          pixel_addr <= '0;
          if (shipGRB) state_reg <= FETCH;
        end
        FETCH: begin
          shift_reg   <= load_word;
          pixel_addr  <= ADDR_FIRST;
          bit_cnt_reg <= '0;
          bit_idx_reg <= '0;
          pix_cnt_reg <= '0;
          state_reg   <= SEND;
        end
        SEND: begin
          dout <= (bit_cnt_reg < (shift_reg[23] ? T1H_CNT : T0H_CNT));
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_reg <= '0;
            if (bit_idx_reg == 5'd23) begin
              bit_idx_reg <= '0;
              if (pix_cnt_reg == PIX_LAST) begin
                rst_cnt_reg <= '0;
                state_reg   <= RESETCODE;
              end else begin
                // Next pixel's word has been waiting on pixel_grb since the address moved.
                shift_reg   <= load_word;
                pix_cnt_reg <= pix_cnt_reg + 1'b1;
                if (pixel_addr != ADDR_LAST) pixel_addr <= pixel_addr + 1'b1;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              shift_reg   <= {shift_reg[22:0], 1'b0};
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        RESETCODE: begin
          if (rst_cnt_reg == '0) Done <= 1'b1;
          if (rst_cnt_reg == RST_LAST) begin
            allDone    <= 1'b1;
            pixel_addr <= '0;
            state_reg  <= IDLE;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grb_serializer.sv
// Bench for grb_serializer: two instances (2 LEDs and 1 LED) fed from bench-side synchronous
// buffers; dout/pixel_addr/Done/allDone compared against a waveform model built from pixel words.
module tb_grb_serializer;

  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int TBIT   = 6;
  localparam int TRESET = 20;

  logic        clk;
  logic        reset;
  logic        ship      [2];
  logic [23:0] pix       [2];
  logic [0:0]  addr      [2];
  logic        dout      [2];
  logic        done      [2];
  logic        alldone   [2];
  logic [23:0] mem       [2][2];

  int n_checks = 0;
  int n_fail   = 0;

  grb_serializer #(
    .NUM_LEDS(2), .ADDR_W(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) u_dut_two (
    .clk(clk), .reset(reset), .shipGRB(ship[0]), .pixel_grb(pix[0]),
    .pixel_addr(addr[0]), .dout(dout[0]), .Done(done[0]), .allDone(alldone[0])
  );

  grb_serializer #(
    .NUM_LEDS(1), .ADDR_W(1), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) u_dut_one (
    .clk(clk), .reset(reset), .shipGRB(ship[1]), .pixel_grb(pix[1]),
    .pixel_addr(addr[1]), .dout(dout[1]), .Done(done[1]), .allDone(alldone[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous pixel buffers: data valid one cycle after the address.
  always @(posedge clk) begin
    pix[0] <= mem[0][addr[0]];
    pix[1] <= mem[1][addr[1]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input logic [23:0] w);
`ifdef GRB_DIM_EN
    exp_word = {w[23:16] >> 2, w[15:8] >> 2, w[7:0] >> 2};
`else
    exp_word = w;
`endif
  endfunction

  task automatic idle_check(input int d, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("idle_dout", dout[d], 0);
      chk("idle_done", done[d], 0);
      chk("idle_alldone", alldone[d], 0);
      chk("idle_addr", addr[d], 0);
    end
  endtask

  // One frame on instance d. hold keeps shipGRB high all frame; chain leaves it high
  // through the allDone cycle so a back-to-back frame follows.
  task automatic run_frame(input int d, input bit hold, input bit chain);
    int n, per, total, p, b, c, hi, ea;
    logic [23:0] w;
    n     = (d == 0) ? 2 : 1;
    per   = 24 * TBIT;
    total = n * per;
    ship[d] = 1'b1;
    @(negedge clk);
    if (!hold) ship[d] = 1'b0;
    chk("fetch_dout", dout[d], 0);
    chk("fetch_addr", addr[d], 0);
    @(negedge clk);
    chk("first_dout", dout[d], 0);
    chk("first_addr", addr[d], (n > 1) ? 1 : 0);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      p  = i / per;
      b  = (i % per) / TBIT;
      c  = i % TBIT;
      w  = exp_word(mem[d][p]);
      hi = w[23 - b] ? T1H : T0H;
      ea = 1 + (i + 1) / per;
      if (ea > n - 1) ea = n - 1;
      chk("send_dout", dout[d], (c < hi) ? 1 : 0);
      chk("send_done", done[d], 0);
      chk("send_alldone", alldone[d], 0);
      chk("send_addr", addr[d], ea);
    end
    @(negedge clk);
    chk("done_pulse", done[d], 1);
    chk("done_dout", dout[d], 0);
    chk("done_addr", addr[d], n - 1);
    for (int j = 1; j < TRESET; j++) begin
      @(negedge clk);
      chk("rc_dout", dout[d], 0);
      chk("rc_done", done[d], 0);
      chk("rc_alldone", alldone[d], 0);
    end
    @(negedge clk);
    chk("alldone_pulse", alldone[d], 1);
    chk("alldone_addr", addr[d], 0);
    chk("alldone_dout", dout[d], 0);
    if (!chain) ship[d] = 1'b0;
    $display("frame dut%0d hold=%0b chain=%0b words=%06h %06h checks=%0d fails=%0d",
             d, hold, chain, mem[d][0], mem[d][1], n_checks, n_fail);
  endtask

  initial begin
    reset   = 1'b1;
    ship[0] = 1'b0;
    ship[1] = 1'b0;
    mem[0][0] = 24'hFF0000; mem[0][1] = 24'h000001;
    mem[1][0] = 24'hAAAAAA; mem[1][1] = 24'h000000;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_dout", dout[d], 0);
      chk("reset_done", done[d], 0);
      chk("reset_alldone", alldone[d], 0);
      chk("reset_addr", addr[d], 0);
    end
    reset = 1'b0;
    idle_check(0, 3);

    // Directed frame, single-cycle request, then the same frame with the request held.
    run_frame(0, 1'b0, 1'b0);
    idle_check(0, 10);
    run_frame(0, 1'b1, 1'b0);
    idle_check(0, 10);

    // Request still high when allDone appears: a second frame follows immediately.
    mem[0][0] = 24'($urandom); mem[0][1] = 24'($urandom);
    run_frame(0, 1'b1, 1'b1);
    mem[0][0] = 24'($urandom); mem[0][1] = 24'($urandom);
    run_frame(0, 1'b1, 1'b0);
    idle_check(0, 5);

    // Single-LED instance: alternating pattern, dimming test word, random words.
    run_frame(1, 1'b0, 1'b0);
    idle_check(1, 3);
    mem[1][0] = 24'hFF80FF;
    run_frame(1, 1'b0, 1'b0);
    idle_check(1, 3);
    for (int r = 0; r < 3; r++) begin
      mem[1][0] = 24'($urandom);
      run_frame(1, r[0], 1'b0);
      idle_check(1, 2);
    end

    // Reset in the middle of SEND aborts with no Done/allDone; next frame restarts at pixel 0.
    mem[0][0] = 24'hFFFFFF; mem[0][1] = 24'h00FF00;
    ship[0] = 1'b1;
    @(negedge clk);
    ship[0] = 1'b0;
    repeat (48) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_dout", dout[0], 0);
    chk("abort_addr", addr[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_alldone", alldone[0], 0);
    reset = 1'b0;
    idle_check(0, 340);
    run_frame(0, 1'b0, 1'b0);
    idle_check(0, 5);

    for (int r = 0; r < 3; r++) begin
      mem[0][0] = 24'($urandom); mem[0][1] = 24'($urandom);
      run_frame(0, r[0], 1'b0);
      idle_check(0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grb_serializer.md
# grb_serializer

Downstream companion of the ship/reset control FSM: on `shipGRB` it fetches NUM_LEDS 24-bit GRB words from a synchronous pixel buffer and serializes them onto the WS2812B data line with cycle-counted high/low widths. After the last bit it pulses `Done`, holds the line low for the >280 µs reset code, then pulses `allDone`. It is the only block that drives the LED strip pin.

## Interface
- NUM_LEDS, 64: pixels per frame, ≥1
- ADDR_W, 6: pixel address width, ≥ $clog2(NUM_LEDS)
- T0H, 40: high cycles for a '0' bit (0.4 µs at 100 MHz)
- T1H, 80: high cycles for a '1' bit (0.8 µs)
- TBIT, 125: cycles per bit period (1.25 µs); requires 0 < T0H < T1H < TBIT
- TRESET, 30000: low cycles of the reset code (300 µs)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- shipGRB  in  1  level; start a frame when sampled high in IDLE
- pixel_grb  in  24  buffer read data {G[7:0],R[7:0],B[7:0]}, valid one cycle after `pixel_addr` changes
- pixel_addr  out  ADDR_W  buffer read address
- dout  out  1  WS2812B serial data, registered
- Done  out  1  one-cycle pulse: all data bits sent, reset code starting
- allDone  out  1  one-cycle pulse: reset code complete

## Operation
- States: IDLE, FETCH, SEND, RESETCODE.
- IDLE: dout=0, pixel_addr=0. shipGRB=1 → FETCH.
- FETCH (1 cycle): pixel_grb for address 0 is valid; load shift register, set pixel_addr=1 (held at NUM_LEDS-1 if NUM_LEDS=1), clear bit/pixel counters → SEND.
- SEND: bit counter 0..TBIT-1; dout=1 while bit counter < (MSB ? T1H : T0H), else 0. MSB first: G7…G0, R7…R0, B7…B0.
- At end of bit 23 of pixel n < NUM_LEDS-1: shift register reloads from pixel_grb, pixel_addr increments (saturates at NUM_LEDS-1). No gap between pixels.
- At end of bit 23 of pixel NUM_LEDS-1 → RESETCODE; Done=1 in its first cycle.
- RESETCODE: dout=0 for TRESET cycles → IDLE; allDone=1 in the first IDLE cycle.
- shipGRB ignored outside IDLE; a mid-frame deassertion does not abort the frame.
- If shipGRB is still high in the IDLE cycle carrying allDone, a new frame starts (control FSM never does this).
- Counters: bit counter $clog2(TBIT), pixel counter $clog2(NUM_LEDS+1), reset counter $clog2(TRESET+1); no wrap in any count.

## Timing
- Reset values: dout=0, pixel_addr=0, Done=0, allDone=0, state IDLE. Reset mid-frame aborts immediately; dout low next cycle.
- shipGRB sampled high in IDLE at edge k → FETCH at k+1 → dout rises at k+2 (first bit's first cycle).
- Frame: exactly NUM_LEDS×24×TBIT SEND cycles; Done one cycle after last bit period ends; allDone TRESET cycles after Done.
- Each bit: exactly TBIT cycles; high width exactly T0H/T1H, zero jitter.

## Configuration
- `GRB_DIM_EN` defined: each 8-bit channel right-shifted by 2 when loaded into the shift register (quarter brightness; bench supply current limit).
- Undefined: pixel_grb loaded unmodified. Timing identical either way.

## Test plan
- Params NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRESET=20; buffer {0xFF0000, 0x000001}; shipGRB pulse → dout high 4 cycles ×8 bits, then 2-cycle highs for remaining 39 bits, last bit high 4; Done at cycle 2+288, allDone 20 cycles later.
- pixel_addr trace same run: 0 in IDLE, 1 after FETCH, stays 1 through end; returns 0 in IDLE.
- shipGRB held high whole run vs 1-cycle pulse → identical dout waveform; only one frame unless high at allDone cycle.
- reset asserted at cycle 50 mid-SEND → next cycle dout=0, pixel_addr=0, no Done/allDone; new shipGRB restarts from pixel 0.
- NUM_LEDS=1, pixel 0xAAAAAA → alternating 4/2-cycle highs ×24, Done then allDone after TRESET.
- With `GRB_DIM_EN`, pixel 0xFF80FF → transmitted word 0x3F203F.
